key_event_ctrl: RTL and testbench
=================================

Name: key_event_ctrl

Overview:
- Memory-mapped controller that sequences the raw push-button inputs for the Nios II software.
- Per key, it synchronises, debounces, detects press edges and latches them into a sticky edge-capture register.
- It raises a maskable interrupt on captured presses.
- It replaces polling of a plain input PIO and sits on the same Avalon-MM slave bus with single-cycle registered reads.

Parameters:
- NKEYS, 2, number of key inputs (1..32).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- ACTIVE_LOW, 1, 1 = key pressed when in_port bit is 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select (word address).
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  NKEYS  raw asynchronous key pins.
- irq  out  1  level interrupt request.

Behaviour:
- Reset: one clk edge with reset=1 clears all of the following:
  - readdata=0, irq=0, mask=0, edgecap=0, all debounce counters=0.
  - Synchroniser flops = unpressed level (all 1 if ACTIVE_LOW, else all 0).
  - Debounced state = 0 (not pressed).
- Reset asserted mid-debounce or mid-transaction aborts it with no partial update.
- Synchroniser: 2-flop chain per bit. pressed_sync = sync2 XOR ACTIVE_LOW.
- Debounce, per key, with counter width = clog2(DEBOUNCE_CYCLES):
  - If pressed_sync == state: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: state <= pressed_sync and counter <= 0.
  - Else counter++.
  - Any glitch back to the old level restarts the count.
  - Latency from in_port change to state change = 2 + DEBOUNCE_CYCLES clk cycles.
- Press event: rise_k = 1 for exactly one cycle, the cycle in which state_k goes 0->1. Releases generate no event.
- Register map. Reads and writes are decoded when chipselect=1. Writes require write_n=0; reads need only chipselect=1.
  - 0 DATA (RO): bits[NKEYS-1:0] = debounced state, upper bits 0. Writes ignored.
  - 1 RESERVED: reads 0, writes ignored.
  - 2 IRQMASK (RW): bits[NKEYS-1:0] = mask, upper bits read 0.
  - 3 EDGECAP (R/W1C): bits[NKEYS-1:0] sticky press flags.
    - A write clears each bit k where writedata[k]=1.
    - If rise_k and a clear of bit k occur in the same cycle, set wins (bit stays 1).
- Read: readdata updates every clk edge to the mux of the currently addressed register when chipselect=1. Otherwise readdata <= 0. Read latency is 1 cycle.
- Write: takes effect on the clk edge where chipselect=1 and write_n=0. A read of the same register in the next cycle returns the new value.
- irq: registered, irq <= |(edgecap & mask).
  - Rises 1 cycle after the edgecap bit sets.
  - Or 1 cycle after the mask write, if edgecap is already set.
  - Falls 1 cycle after the clearing write or mask clear.
- Two keys accepted in the same cycle set both edgecap bits in that cycle.
- Holding a key produces one event only; a new event requires a debounced release then press.

Test Plan:
- Reset: NKEYS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, in_port=2'b11, pulse reset -> readdata=0, irq=0; reads of addr 0/2/3 return 0.
- Clean press on key0 (in_port 11->10 at cycle T) -> DATA=0x1 first visible on read issued at T+6; EDGECAP=0x1; with IRQMASK=0x1, irq=1 at T+7.
- Bounce: in_port bit0 toggles low 3 cycles, high 1, low 3, high -> DATA stays 0, EDGECAP stays 0, irq stays 0.
- W1C: EDGECAP=0x3, write 0x1 to addr 3 -> EDGECAP=0x2. Then write 0x2 in the same cycle a fresh key1 press is accepted -> EDGECAP remains 0x2.
- Mask gating: EDGECAP=0x2, IRQMASK=0 -> irq=0. Write IRQMASK=0x2 -> irq=1 next cycle. Write IRQMASK=0 -> irq=0 next cycle.
- Reset mid-debounce: key0 low for 3 of 4 cycles, assert reset, release reset with key still low -> DATA=0 until a full 2+4 cycles after reset deassertion, then DATA=0x1 and EDGECAP=0x1.

Source files
------------

// File: rtl/key_event_ctrl.sv
// Push-button controller: per-key synchroniser, debounce, press-edge capture
// and maskable level interrupt behind an Avalon-MM slave with registered reads.
module key_event_ctrl #(
    parameter int NKEYS           = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [NKEYS-1:0] in_port,
    output logic             irq
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [NKEYS-1:0] IDLE_LVL = {NKEYS{ACTIVE_LOW}};

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q [NKEYS];
    logic [CNT_W-1:0] cnt_d [NKEYS];
    logic [NKEYS-1:0] mask_q, mask_d;
    logic [NKEYS-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [NKEYS-1:0] pressed_sync;
    logic [NKEYS-1:0] rise;
    logic [NKEYS-1:0] clr;
    logic             wr_en;
    logic [NKEYS-1:0] wdata_keys;

    assign wr_en      = chipselect & ~write_n;
    assign wdata_keys = writedata[NKEYS-1:0];

    generate
        if (NKEYS < 32) begin : g_wdata_upper
            logic unused_wdata_upper;
            assign unused_wdata_upper = ^writedata[31:NKEYS];
        end
    endgenerate

    assign pressed_sync = sync2_q ^ IDLE_LVL;

    // Any sample disagreeing with the debounced state must persist for the
    // full window; a single agreeing sample resets the count.
    always_comb begin
        state_d = state_q;
        for (int k = 0; k < NKEYS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (pressed_sync[k] == state_q[k]) begin
                cnt_d[k] = '0;
            end else if (cnt_q[k] == CNT_MAX) begin
                state_d[k] = pressed_sync[k];
                cnt_d[k]   = '0;
            end else begin
                cnt_d[k] = cnt_q[k] + CNT_ONE;
            end
        end
    end

    // Press events are taken from the accepting edge so edgecap lands together with state.
    assign rise = state_d & ~state_q;
    assign clr  = (wr_en && address == ADDR_EDGECAP) ? wdata_keys : '0;

    always_comb begin
        mask_d    = mask_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            mask_d = wdata_keys;
        end
        edgecap_d = (edgecap_q & ~clr) | rise;
        irq_d     = |(edgecap_q & mask_q);
    end

    always_comb begin
        readdata_d = '0;
        if (chipselect) begin
            unique case (address)
                ADDR_DATA:    readdata_d = 32'(state_q);
                ADDR_IRQMASK: readdata_d = 32'(mask_q);
                ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
                default:      readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= IDLE_LVL;
            sync2_q    <= IDLE_LVL;
            state_q    <= '0;
            mask_q     <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            mask_q     <= mask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            for (int k = 0; k < NKEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: NKEYS=2, DEBOUNCE_CYCLES=4, active-low keys.
module tb_key_event_ctrl;

    localparam int NK = 2;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [NK-1:0] in_port;
    logic          irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    key_event_ctrl #(
        .NKEYS          (NK),
        .DEBOUNCE_CYCLES(DB),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        tick(1);
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    initial begin
        logic [31:0] d;
        reset      = 1'b1;
        in_port    = 2'b11;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        tick(2);
        reset = 1'b0;
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rd(2'd0, d); check("reset_data", d, 32'h0);
        rd(2'd1, d); check("reset_rsvd", d, 32'h0);
        rd(2'd2, d); check("reset_mask", d, 32'h0);
        rd(2'd3, d); check("reset_edgecap", d, 32'h0);

        wr(2'd2, 32'hFFFF_FFFD);
        rd(2'd2, d); check("mask_readback", d, 32'h1);
        wr(2'd2, 32'h1);

        // Clean press on key0, continuous read of DATA
        in_port    = 2'b10;
        chipselect = 1'b1;
        address    = 2'd0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (i == 6) begin
                check("press_data_t6", readdata, 32'h0);
                check("press_irq_t6", {31'd0, irq}, 32'h0);
            end
            if (i == 7) begin
                check("press_data_t7", readdata, 32'h1);
                check("press_irq_t7", {31'd0, irq}, 32'h1);
            end
        end
        chipselect = 1'b0;
        rd(2'd3, d); check("press_edgecap", d, 32'h1);
        wr(2'd0, 32'h0);
        rd(2'd0, d); check("data_ro", d, 32'h1);

        // Release generates no event; then W1C clears it
        in_port = 2'b11;
        tick(8);
        rd(2'd0, d); check("release_data", d, 32'h0);
        rd(2'd3, d); check("release_edgecap", d, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, d); check("clear_edgecap", d, 32'h0);
        check("clear_irq", {31'd0, irq}, 32'h0);

        // Bounce never survives the full window
        in_port = 2'b10; tick(3);
        in_port = 2'b11; tick(1);
        in_port = 2'b10; tick(3);
        in_port = 2'b11; tick(8);
        rd(2'd0, d); check("bounce_data", d, 32'h0);
        rd(2'd3, d); check("bounce_edgecap", d, 32'h0);
        check("bounce_irq", {31'd0, irq}, 32'h0);

        // Both keys together, partial W1C
        in_port = 2'b00;
        tick(8);
        rd(2'd3, d); check("both_edgecap", d, 32'h3);
        check("both_irq", {31'd0, irq}, 32'h1);
        wr(2'd3, 32'h1);
        rd(2'd3, d); check("w1c_partial", d, 32'h2);
        in_port = 2'b11;
        tick(8);
        rd(2'd3, d); check("held_no_new", d, 32'h2);

        // Fresh key1 press accepted on the same edge as its clear: set wins
        in_port = 2'b01;
        tick(5);
        wr(2'd3, 32'h2);
        rd(2'd3, d); check("set_wins", d, 32'h2);
        rd(2'd0, d); check("key1_data", d, 32'h2);
        check("key1_masked_irq", {31'd0, irq}, 32'h0);

        // Mask gating
        wr(2'd2, 32'h0);
        check("mask0_irq", {31'd0, irq}, 32'h0);
        wr(2'd2, 32'h2);
        check("mask_set_irq_same", {31'd0, irq}, 32'h0);
        tick(1);
        check("mask_set_irq_next", {31'd0, irq}, 32'h1);
        wr(2'd2, 32'h0);
        check("mask_clr_irq_same", {31'd0, irq}, 32'h1);
        tick(1);
        check("mask_clr_irq_next", {31'd0, irq}, 32'h0);

        // Reset mid-debounce
        in_port = 2'b11;
        tick(8);
        wr(2'd3, 32'h3);
        rd(2'd3, d); check("pre_rst_edgecap", d, 32'h0);
        wr(2'd2, 32'h1);
        in_port = 2'b10;
        tick(5);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("midrst_readdata", readdata, 32'h0);
        check("midrst_irq", {31'd0, irq}, 32'h0);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = 2'd0;
        for (int i = 1; i <= 7; i++) begin
            tick(1);
            if (i == 6) check("midrst_data_t6", readdata, 32'h0);
            if (i == 7) check("midrst_data_t7", readdata, 32'h1);
        end
        chipselect = 1'b0;
        rd(2'd3, d); check("midrst_edgecap", d, 32'h1);
        rd(2'd2, d); check("midrst_mask", d, 32'h0);
        check("midrst_irq_masked", {31'd0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
